// File: rtl/mem_access_unit.sv
// Memory access unit between the MEM stage and a word-only data memory.
// Provides sub-word loads with extension, read-modify-write sub-word stores and access trapping.
module mem_access_unit #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned DEPTH_WORDS = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic [1:0]  SZ_B     = 2'b00;
    localparam logic [1:0]  SZ_H     = 2'b01;
    localparam logic [1:0]  SZ_W     = 2'b10;
    // 33-bit bounds so the upper limit cannot wrap
    localparam logic [32:0] ADDR_LO  = 33'(BASE_ADDR);
    localparam logic [32:0] ADDR_HI  = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) << 2);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state, state_n;
    logic        illegal;
    logic [31:0] aligned_addr;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [31:0] merge_q;
    logic [31:0] addr_q;

    assign aligned_addr = {req_addr[31:2], 2'b00};
    assign byte_lane    = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    assign half_lane    = mem_rdata[{req_addr[1], 4'b0000} +: 16];

    // Alignment and range legality of the presented request
    always_comb begin
        illegal = 1'b0;
        case (req_size)
            SZ_B:    illegal = 1'b0;
            SZ_H:    illegal = req_addr[0];
            SZ_W:    illegal = |req_addr[1:0];
            default: illegal = 1'b1;
        endcase
        if (({1'b0, req_addr} < ADDR_LO) || ({1'b0, req_addr} >= ADDR_HI))
            illegal = 1'b1;
    end

    // Load lane extraction and store lane merge
    always_comb begin
        load_ext = mem_rdata;
        merged   = mem_rdata;
        case (req_size)
            SZ_B: begin
                load_ext = req_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
                merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
            end
            SZ_H: begin
                load_ext = req_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
                merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
            end
            default: begin
                load_ext = mem_rdata;
                merged   = mem_rdata;
            end
        endcase
    end

    // Next state and memory-side controls; all enables forced low while in reset
    always_comb begin
        state_n   = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stall     = 1'b0;
        mem_addr  = aligned_addr;
        mem_wdata = req_wdata;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (req_valid && !illegal) begin
                        if (!req_we) begin
                            mem_read = 1'b1;
                        end else if (req_size == SZ_W) begin
                            mem_write = 1'b1;
                        end else begin
                            mem_read = 1'b1;
                            stall    = 1'b1;
                            state_n  = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    mem_write = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = merge_q;
                    state_n   = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            fault      <= 1'b0;
            fault_addr <= 32'h0;
            merge_q    <= 32'h0;
            addr_q     <= 32'h0;
        end else begin
            state      <= state_n;
            load_valid <= 1'b0;
            fault      <= 1'b0;
            if ((state == IDLE) && req_valid) begin
                if (illegal) begin
                    fault      <= 1'b1;
                    fault_addr <= req_addr;
                end else if (!req_we) begin
                    load_data  <= load_ext;
                    load_valid <= 1'b1;
                end else if (req_size != SZ_W) begin
                    merge_q <= merged;
                    addr_q  <= aligned_addr;
                end
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the pipeline MEM stage and the word-only data memory; drives that memory's read, write, address and data inputs and consumes its combinational read result.
- Adds byte and halfword loads, with sign or zero extension.
- Adds byte and halfword stores through a two-cycle read-modify-write, stalling the pipeline for the second cycle.
- Traps misaligned and out-of-range accesses before they reach memory.

Parameters:
- BASE_ADDR, 1024: first byte address mapped to memory word 0.
- DEPTH_WORDS, 65536: number of 32-bit words in the data memory.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  pipeline presents a memory operation this cycle.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the sub-word value is in the low bits.
- mem_rdata  in  32  data memory read result.
- mem_read  out  1  data memory read enable.
- mem_write  out  1  data memory write enable.
- mem_addr  out  32  word-aligned byte address, req_addr with bits [1:0] cleared.
- mem_wdata  out  32  data memory write data.
- stall  out  1  pipeline must hold its request and freeze.
- load_data  out  32  registered load result.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- fault  out  1  one-cycle registered pulse for a rejected access.
- fault_addr  out  32  byte address of the most recent fault.

Behaviour:
- Reset (rst=0, async): state=IDLE; load_data=0, load_valid=0, fault=0, fault_addr=0. Combinational outputs mem_read, mem_write, stall are 0.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24. Halfword addr[1]=0 selects bits 15:0.
- Legality check, only when req_valid=1 in IDLE: illegal if any of the following holds:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr<BASE_ADDR;
  - addr>=BASE_ADDR+4*DEPTH_WORDS.
- On an illegal request: no mem_read, no mem_write, no stall. Next edge: fault=1, fault_addr=req_addr, load_valid=0.
- States are IDLE and RMW_WR.
- IDLE, legal load: mem_read=1 combinationally. Next edge: load_data = extracted lane, extended per req_unsigned, and load_valid=1. Latency 1, no stall.
- IDLE, legal word store: mem_write=1 and mem_wdata=req_wdata in the same cycle; memory commits at that edge. No stall.
- IDLE, legal byte/half store:
  - Same cycle: mem_read=1, stall=1.
  - Next edge: merge register = mem_rdata with the target lane replaced by req_wdata[7:0] or [15:0]; latch the aligned address; go to RMW_WR.
- RMW_WR:
  - mem_write=1, mem_addr=latched address, mem_wdata=merge register, stall=0; return to IDLE at the next edge.
  - req_* inputs are ignored in this cycle; the pipeline advances after it.
- load_valid and fault are single-cycle pulses and deassert at the next edge unless re-triggered.
- req_valid=0 in IDLE: all enables 0, no state change.
- Reset asserted during RMW_WR: the write is abandoned; mem_write drops immediately and the state returns to IDLE.
- At most one of mem_read and mem_write is high in any cycle.

Test Plan:
1. Word store then load: store 0xDEADBEEF at 1028, then load word at 1028 -> mem_write pulse with mem_addr=1028; load_valid next cycle with load_data=0xDEADBEEF; stall never 1.
2. Byte RMW: memory[1028]=0x11223344; byte store 0xAB at 1030 -> cycle 0 has stall=1 and mem_read=1; cycle 1 has mem_write=1 with mem_wdata=0x11AB3344; the stored word reads back as 0x11AB3344.
3. Sub-word loads: memory[1032]=0x80FF7F01 ->
   - signed byte at 1034 gives 0xFFFFFFFF;
   - unsigned byte at 1034 gives 0x000000FF;
   - signed half at 1034 gives 0xFFFF80FF;
   - signed half at 1032 gives 0x00007F01.
4. Faults -> each yields fault=1 next cycle, with no mem_read and no mem_write:
   - word at 1026, fault_addr=1026;
   - half at 1033;
   - load at 1020;
   - load at 1024+4*65536;
   - req_size=11.
5. Reset mid-RMW: half store 0xBEEF at 1040, rst=0 during the RMW_WR cycle -> mem_write=0 immediately; state IDLE; the memory word at 1040 is unchanged.
6. Back-to-back: byte store, then a load held by the pipeline through the stall -> exactly one mem_write; the load is issued only after RMW_WR and returns the merged word's lane.
